aes_spi_stream: RTL and testbench
=================================

# aes_spi_stream

Single-clock SPI front end and block sequencer for the AES accelerator: receives a command header, an optional key, and a burst of 1..MAXBLK 128-bit blocks within one chip-enable window. It launches the attached AES core once per block and streams each result back full-duplex while the next block shifts in. It replaces the one-shot, sclk-domain shift register with a clk-domain, multi-block, key-reuse-capable controller that sits between the Pi SPI pins and `aes_core`.

## Interface
Parameters:
- K, 128: key length in bits; 128, 192 or 256. Any other value is an elaboration error.
- MAXBLK, 16: maximum blocks per transaction, 1..16.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- r_sclk  in  1  SPI clock from the Pi (asynchronous).
- r_mosi  in  1  SPI data in (asynchronous).
- r_ce  in  1  chip enable, high for the whole transaction (asynchronous).
- r_miso  out  1  SPI data out.
- done  out  1  high once all results have been shifted out; cleared on the next r_ce rise.
- err  out  1  sticky protocol error; cleared on the next r_ce rise.
- core_start  out  1  one-cycle launch pulse to the core.
- core_key  out  K  key to the core.
- core_msg  out  128  block to the core.
- core_dir  out  1  0 = encrypt, 1 = decrypt.
- core_done  in  1  one-cycle pulse from the core when core_result is valid.
- core_result  in  128  core output.

## Operation
- r_sclk, r_mosi and r_ce pass through 2-flop synchronizers. Edges are detected from the second and third flops. clk must be at least 4x r_sclk.
- SPI mode 0, MSB first. MOSI is sampled on the detected sclk rise. MISO is updated on the detected sclk fall.
- Frame within one r_ce window:
  - Header, 8 bits: bit0 = dir; bit1 = keep_key; bits[7:4] = N−1.
  - Key, K bits; present only when keep_key = 0.
  - N message blocks, 128 bits each.
  - 128 drain bits.
- States and transitions:
  - IDLE -> HDR on the r_ce rise. This clears done, err and all counters.
  - HDR -> KEY after 8 bits if keep_key = 0. HDR -> BLK after 8 bits if keep_key = 1.
  - KEY -> BLK after K bits. The key is latched into core_key and key_valid is set.
  - BLK: after each 128th bit, latch core_msg, pulse core_start, and increment the block count. After block N, go to DRAIN.
  - DRAIN -> DONE after 128 bits. done is set.
  - Any state -> IDLE on the r_ce fall.
- A 128-bit result buffer captures core_result on core_done.
- At the first bit of block i (i ≥ 1) and at the first drain bit, the buffer loads into the MISO shift register.
- r_miso is 0 during the header, the key and block 0.
- Errors set err and make the block ignore all further bits until r_ce falls; r_miso is forced to 0 while err is set:
  - N > MAXBLK.
  - keep_key = 1 while key_valid = 0.
  - Overrun: the result buffer is not loaded from the previous block when its shift-out must start.
  - r_ce falls before DONE (truncated frame).
- core_key, core_msg and core_dir hold stable from core_start until the next core_start.
- core_key and key_valid persist across transactions and are lost only on reset.
- Reset mid-transaction:
  - Return to IDLE with outputs at reset values and key_valid = 0.
  - Resume only after a fresh r_ce rise.

## Timing
- Reset values: r_miso = 0, done = 0, err = 0, core_start = 0, core_key = 0, core_msg = 0, core_dir = 0.
- Bit on r_mosi at an sclk rise is in the shift register 3 clk later.
- core_start asserts 1 clk after the 128th bit of a block is shifted in.
- r_miso changes 3 clk after each pin-level sclk fall. The first result bit is valid before the first sclk rise of the next block.
- done rises 1 clk after the last drain bit is sampled and holds until the next r_ce rise or reset.
- If core_done and a shift-out load occur in the same cycle, the load takes the new core_result (bypass), not the stale buffer.
- r_ce rise and fall are each registered 3 clk after the pin edge; sclk edges seen while the synchronized r_ce is low are ignored.

## Test plan
- AES-128 (K=128): header 0x00, key 000102…0f, block 00112233445566778899aabbccddeeff, 128 drain clocks -> drain MISO = 69c4e0d86a7b0430d8cdb78070b4c55a, done = 1, err = 0, one core_start pulse.
- Burst: header 0x20 (N = 3, encrypt), same key, blocks P0, P1, P2 -> MISO during blocks 1, 2 and drain = E(P0), E(P1), E(P2); exactly 3 core_start pulses.
- Key reuse and decrypt: header 0x03 with no key field after the first test, block 69c4…c55a -> MISO = 00112233…eeff. Repeat immediately after reset -> err = 1, no core_start, MISO all 0.
- Overrun: a stub core that delays core_done past the next block boundary -> err = 1 at the first bit of block 1, r_miso = 0, done stays 0.
- Abort: drop r_ce after 40 key bits, then a full valid frame -> first frame sets err with no core_start; second frame completes with err = 0 and a correct result.
- Reset mid-block (after 64 bits of block 0) -> all outputs 0 next clk, key_valid cleared; a following keep_key frame flags err.

Source files
------------

// File: rtl/aes_spi_stream.sv
// aes_spi_stream: clk-domain SPI (mode 0, MSB first) front end and block
// sequencer for aes_core. One r_ce window carries an 8-bit header, an optional
// K-bit key and 1..MAXBLK 128-bit blocks, followed by 128 drain bits. Each
// block launches the core once. The previous block's result streams out on
// MISO while the next block streams in.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   r_sclk, r_mosi, r_ce   asynchronous SPI pins from the host
//   r_miso                 SPI data out (forced low while err is set)
//   done, err              frame complete / sticky protocol error
//   core_start             one-cycle launch pulse to the core
//   core_key/msg/dir       operands, stable between launches
//   core_done, core_result result handshake from the core
module aes_spi_stream #(
  parameter int K      = 128,
  parameter int MAXBLK = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           r_sclk,
  input  logic           r_mosi,
  input  logic           r_ce,
  output logic           r_miso,
  output logic           done,
  output logic           err,
  output logic           core_start,
  output logic [K-1:0]   core_key,
  output logic [127:0]   core_msg,
  output logic           core_dir,
  input  logic           core_done,
  input  logic [127:0]   core_result
);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("aes_spi_stream: K must be 128, 192 or 256");
  end
  if (MAXBLK < 1 || MAXBLK > 16) begin : g_bad_maxblk
    $error("aes_spi_stream: MAXBLK must be in 1..16");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_KEY, S_BLK, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     sclk_sy, ce_sy;
  logic [1:0]     mosi_sy;
  logic [7:0]     bit_cnt;
  logic [3:0]     blk_cnt, nm1_q;
  logic           dir_q, key_valid;
  logic           load_pend, res_valid;
  logic [126:0]   sh;
  logic [K-2:0]   key_sh;
  logic [127:0]   res_buf, miso_sr;
  logic           err_set;

  // Synchronizers: flops [0],[1] resynchronize, edges come from [1] vs [2].
  always_ff @(posedge clk) begin
    sclk_sy <= {sclk_sy[1:0], r_sclk};
    ce_sy   <= {ce_sy[1:0], r_ce};
    mosi_sy <= {mosi_sy[0], r_mosi};
  end

  logic sclk_rise, sclk_fall, ce_rise, ce_fall, mosi_bit;
  assign ce_rise   = ce_sy[1] & ~ce_sy[2];
  assign ce_fall   = ~ce_sy[1] & ce_sy[2];
  assign sclk_rise = sclk_sy[1] & ~sclk_sy[2] & ce_sy[1];
  assign sclk_fall = ~sclk_sy[1] & sclk_sy[2] & ce_sy[1];
  assign mosi_bit  = mosi_sy[1];

  logic [7:0] hdr_word;
  logic       bad_hdr, res_ready, load_now, overrun;
  assign hdr_word  = {sh[6:0], mosi_bit};
  assign bad_hdr   = ({1'b0, hdr_word[7:4]} >= 5'(MAXBLK)) ||
                     (hdr_word[1] && !key_valid);
  // A pending result may be picked up from the buffer or straight off the core.
  assign res_ready = res_valid | core_done;
  assign load_now  = load_pend & res_ready;
  // The first rise of the next segment is the last moment the result may land.
  assign overrun   = sclk_rise && load_pend && !res_ready && (bit_cnt == 8'd0) &&
                     (state_q == S_BLK || state_q == S_DRAIN);

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    if (ce_fall) begin
      state_d = S_IDLE;
      if (state_q != S_IDLE && state_q != S_DONE) err_set = 1'b1;
    end else if (ce_rise) begin
      state_d = S_HDR;
    end else if (overrun) begin
      state_d = S_ERR;
      err_set = 1'b1;
    end else if (sclk_rise) begin
      case (state_q)
        S_HDR: if (bit_cnt == 8'd7) begin
          if (bad_hdr) begin
            state_d = S_ERR;
            err_set = 1'b1;
          end else begin
            state_d = hdr_word[1] ? S_BLK : S_KEY;
          end
        end
        S_KEY:   if (bit_cnt == 8'(K - 1)) state_d = S_BLK;
        S_BLK:   if (bit_cnt == 8'd127 && blk_cnt == nm1_q) state_d = S_DRAIN;
        S_DRAIN: if (bit_cnt == 8'd127) state_d = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt    <= '0;
      blk_cnt    <= '0;
      nm1_q      <= '0;
      dir_q      <= 1'b0;
      key_valid  <= 1'b0;
      load_pend  <= 1'b0;
      res_valid  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_start <= 1'b0;
      core_key   <= '0;
      core_msg   <= '0;
      core_dir   <= 1'b0;
      miso_sr    <= '0;
    end else begin
      state_q    <= state_d;
      core_start <= 1'b0;
      if (err_set) err <= 1'b1;
      if (ce_rise) begin
        done      <= 1'b0;
        err       <= 1'b0;
        bit_cnt   <= '0;
        blk_cnt   <= '0;
        load_pend <= 1'b0;
        res_valid <= 1'b0;
        miso_sr   <= '0;
      end else begin
        if (load_now) begin
          miso_sr   <= core_done ? core_result : res_buf;
          load_pend <= 1'b0;
          res_valid <= 1'b0;
        end else begin
          if (core_done) res_valid <= 1'b1;
          // The fall right after a segment's last rise (bit_cnt wrapped to 0)
          // must not shift: the next result's MSB waits for the coming rise.
          if (sclk_fall && bit_cnt != 8'd0 && (state_q == S_BLK || state_q == S_DRAIN))
            miso_sr <= {miso_sr[126:0], 1'b0};
        end
        if (sclk_rise && !overrun) begin
          case (state_q)
            S_HDR: if (bit_cnt == 8'd7) begin
              bit_cnt <= '0;
              dir_q   <= hdr_word[0];
              nm1_q   <= hdr_word[7:4];
            end else bit_cnt <= bit_cnt + 8'd1;
            S_KEY: if (bit_cnt == 8'(K - 1)) begin
              bit_cnt   <= '0;
              core_key  <= {key_sh, mosi_bit};
              key_valid <= 1'b1;
            end else bit_cnt <= bit_cnt + 8'd1;
            S_BLK: if (bit_cnt == 8'd127) begin
              bit_cnt    <= '0;
              core_msg   <= {sh, mosi_bit};
              core_dir   <= dir_q;
              core_start <= 1'b1;
              load_pend  <= 1'b1;
              if (blk_cnt != nm1_q) blk_cnt <= blk_cnt + 4'd1;
            end else bit_cnt <= bit_cnt + 8'd1;
            S_DRAIN: if (bit_cnt == 8'd127) begin
              bit_cnt <= '0;
              done    <= 1'b1;
            end else bit_cnt <= bit_cnt + 8'd1;
            default: ;
          endcase
        end
      end
    end
  end

  // Input shift paths and result buffer carry data only.
  always_ff @(posedge clk) begin
    if (sclk_rise) begin
      sh <= {sh[125:0], mosi_bit};
      if (state_q == S_KEY) key_sh <= {key_sh[K-3:0], mosi_bit};
    end
    if (core_done) res_buf <= core_result;
  end

  assign r_miso = miso_sr[127] & ~err;

endmodule

// File: tb/tb_aes_spi_stream.sv
// Bench for aes_spi_stream: drives SPI frames bit by bit, runs a stub cipher
// core with programmable latency, and compares the MISO stream and status
// against expectations derived from the frame layout.
module tb_aes_spi_stream;
  localparam int K      = 128;
  localparam int MAXBLK = 4;
  localparam int HALF   = 40;

  logic clk = 1'b0, reset = 1'b1, r_sclk = 1'b0, r_mosi = 1'b0, r_ce = 1'b0;
  logic r_miso, done, err, core_start, core_dir;
  logic [K-1:0] core_key;
  logic [127:0] core_msg;
  logic core_done = 1'b0;
  logic [127:0] core_result = '0;

  int errors = 0, checks = 0;
  int core_lat = 5, start_cnt = 0, busy = 0;
  logic [127:0] job_msg, job_key;
  logic job_dir;
  logic [127:0] blk[4];
  logic [127:0] seg[5];
  logic [127:0] rx_hdr, rx_key, rx;
  logic [127:0] key0;

  aes_spi_stream #(.K(K), .MAXBLK(MAXBLK)) dut (
    .clk(clk), .reset(reset), .r_sclk(r_sclk), .r_mosi(r_mosi), .r_ce(r_ce),
    .r_miso(r_miso), .done(done), .err(err), .core_start(core_start),
    .core_key(core_key), .core_msg(core_msg), .core_dir(core_dir),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  // Toy invertible cipher standing in for aes_core.
  function automatic logic [127:0] enc_ref(input logic [127:0] m, input logic [127:0] k);
    return {m[114:0], m[127:115]} ^ k;
  endfunction
  function automatic logic [127:0] dec_ref(input logic [127:0] c, input logic [127:0] k);
    logic [127:0] x;
    x = c ^ k;
    return {x[12:0], x[127:13]};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    core_done <= 1'b0;
    if (core_start) begin
      job_msg   <= core_msg;
      job_key   <= core_key;
      job_dir   <= core_dir;
      busy      <= core_lat;
      start_cnt <= start_cnt + 1;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        core_done   <= 1'b1;
        core_result <= job_dir ? dec_ref(job_msg, job_key) : enc_ref(job_msg, job_key);
      end
    end
  end

  task automatic ce_up();
    r_ce = 1'b1;
    repeat (6) @(posedge clk);
    #2;
  endtask
  task automatic ce_down();
    r_ce = 1'b0;
    repeat (6) @(posedge clk);
    #2;
  endtask
  task automatic gap();
    repeat (20) @(posedge clk);
    #2;
  endtask

  task automatic xfer(input logic [127:0] tx, input int nbits, output logic [127:0] rxw);
    rxw = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      r_mosi = tx[i];
      #(HALF);
      rxw = {rxw[126:0], r_miso};
      r_sclk = 1'b1;
      #(HALF);
      r_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr, input bit with_key,
                            input logic [127:0] key, input int nblk);
    ce_up();
    xfer({120'd0, hdr}, 8, rx_hdr);
    if (with_key) xfer(key, K, rx_key);
    else rx_key = '0;
    for (int b = 0; b < nblk; b++) begin
      xfer(blk[b], 128, seg[b]);
      gap();
    end
    xfer('0, 128, seg[nblk]);
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (r_miso !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b want 0", r_miso); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", core_start); end
    checks++; if (core_key !== '0) begin errors++; $display("FAIL rst_key: got %h want 0", core_key); end
    checks++; if (core_msg !== '0) begin errors++; $display("FAIL rst_msg: got %h want 0", core_msg); end
    checks++; if (core_dir !== 1'b0) begin errors++; $display("FAIL rst_dir: got %b want 0", core_dir); end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_single();
    int s0;
    s0 = start_cnt;
    key0 = 128'h000102030405060708090a0b0c0d0e0f;
    blk[0] = 128'h00112233445566778899aabbccddeeff;
    send_frame(8'h00, 1, key0, 1);
    checks++; if (rx_hdr !== '0) begin errors++; $display("FAIL single_hdr_miso: got %h want 0", rx_hdr); end
    checks++; if (rx_key !== '0) begin errors++; $display("FAIL single_key_miso: got %h want 0", rx_key); end
    checks++; if (seg[0] !== '0) begin errors++; $display("FAIL single_blk0_miso: got %h want 0", seg[0]); end
    checks++; if (seg[1] !== enc_ref(blk[0], key0)) begin errors++; $display("FAIL single_drain: got %h want %h", seg[1], enc_ref(blk[0], key0)); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
    checks++; if (core_key !== key0) begin errors++; $display("FAIL single_core_key: got %h want %h", core_key, key0); end
    checks++; if (core_msg !== blk[0]) begin errors++; $display("FAIL single_core_msg: got %h want %h", core_msg, blk[0]); end
    ce_down();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done_hold: got %b want 1", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err_after_ce: got %b want 0", err); end
  endtask

  task automatic test_burst();
    int s0;
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) blk[i] = rnd128();
    send_frame(8'h20, 1, key0, 3);
    checks++; if (seg[0] !== '0) begin errors++; $display("FAIL burst_blk0_miso: got %h want 0", seg[0]); end
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (seg[i] !== enc_ref(blk[i-1], key0)) begin
        errors++; $display("FAIL burst_seg%0d: got %h want %h", i, seg[i], enc_ref(blk[i-1], key0));
      end
    end
    checks++; if (start_cnt - s0 !== 3) begin errors++; $display("FAIL burst_starts: got %0d want 3", start_cnt - s0); end
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL burst_status: got done=%b err=%b want done=1 err=0", done, err); end
    ce_down();
  endtask

  task automatic test_key_reuse_decrypt();
    int s0;
    logic [127:0] p;
    s0 = start_cnt;
    p = rnd128();
    blk[0] = enc_ref(p, key0);
    send_frame(8'h03, 0, '0, 1);
    checks++; if (seg[1] !== p) begin errors++; $display("FAIL reuse_plain: got %h want %h", seg[1], p); end
    checks++; if (seg[0] !== '0) begin errors++; $display("FAIL reuse_blk0_miso: got %h want 0", seg[0]); end
    checks++; if (core_dir !== 1'b1) begin errors++; $display("FAIL reuse_dir: got %b want 1", core_dir); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL reuse_starts: got %0d want 1", start_cnt - s0); end
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL reuse_status: got done=%b err=%b want done=1 err=0", done, err); end
    ce_down();
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int s0, n;
      bit dir;
      logic [127:0] k;
      logic [127:0] want;
      s0  = start_cnt;
      n   = $urandom_range(1, 4);
      dir = 1'($urandom_range(0, 1));
      k   = rnd128();
      for (int i = 0; i < n; i++) blk[i] = rnd128();
      send_frame({4'(n - 1), 3'b000, dir}, 1, k, n);
      for (int i = 1; i <= n; i++) begin
        want = dir ? dec_ref(blk[i-1], k) : enc_ref(blk[i-1], k);
        checks++;
        if (seg[i] !== want) begin errors++; $display("FAIL rand%0d_seg%0d: got %h want %h", it, i, seg[i], want); end
      end
      checks++; if (start_cnt - s0 !== n) begin errors++; $display("FAIL rand%0d_starts: got %0d want %0d", it, start_cnt - s0, n); end
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rand%0d_status: got done=%b err=%b want done=1 err=0", it, done, err); end
      ce_down();
    end
  endtask

  task automatic test_maxblk();
    int s0;
    s0 = start_cnt;
    ce_up();
    xfer({120'd0, 8'h40}, 8, rx_hdr);
    repeat (4) @(posedge clk);
    #2;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL maxblk_err: got %b want 1", err); end
    xfer(rnd128(), 128, rx);
    checks++; if (rx !== '0) begin errors++; $display("FAIL maxblk_miso: got %h want 0", rx); end
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL maxblk_starts: got %0d want 0", start_cnt - s0); end
    ce_down();
    checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL maxblk_status: got err=%b done=%b want err=1 done=0", err, done); end
  endtask

  task automatic test_overrun();
    int s0;
    s0 = start_cnt;
    core_lat = 100;
    blk[0] = rnd128();
    blk[1] = rnd128();
    ce_up();
    xfer({120'd0, 8'h10}, 8, rx_hdr);
    xfer(key0, K, rx_key);
    xfer(blk[0], 128, rx);
    gap();
    xfer(blk[1], 1, rx);
    repeat (6) @(posedge clk);
    #2;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL overrun_err: got %b want 1", err); end
    checks++; if (r_miso !== 1'b0) begin errors++; $display("FAIL overrun_miso: got %b want 0", r_miso); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL overrun_done: got %b want 0", done); end
    ce_down();
    repeat (150) @(posedge clk);
    #2;
    checks++; if (done !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL overrun_after: got done=%b err=%b want done=0 err=1", done, err); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL overrun_starts: got %0d want 1", start_cnt - s0); end
    core_lat = 5;
  endtask

  task automatic test_abort();
    int s0;
    logic [127:0] k1;
    s0 = start_cnt;
    ce_up();
    xfer({120'd0, 8'h00}, 8, rx_hdr);
    xfer(key0, 40, rx_key);
    ce_down();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b want 1", err); end
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL abort_starts: got %0d want 0", start_cnt - s0); end
    k1 = rnd128();
    blk[0] = rnd128();
    send_frame(8'h00, 1, k1, 1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_next_err: got %b want 0", err); end
    checks++; if (seg[1] !== enc_ref(blk[0], k1)) begin errors++; $display("FAIL abort_next_result: got %h want %h", seg[1], enc_ref(blk[0], k1)); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_next_done: got %b want 1", done); end
    ce_down();
  endtask

  task automatic test_reset_mid();
    int s0;
    blk[0] = rnd128();
    ce_up();
    xfer({120'd0, 8'h00}, 8, rx_hdr);
    xfer(key0, K, rx_key);
    xfer(blk[0], 64, rx);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    checks++; if (core_key !== '0) begin errors++; $display("FAIL rmid_key: got %h want 0", core_key); end
    checks++; if (core_msg !== '0) begin errors++; $display("FAIL rmid_msg: got %h want 0", core_msg); end
    checks++; if ({r_miso, done, err, core_start, core_dir} !== 5'b0) begin
      errors++; $display("FAIL rmid_ctrl: got %b want 00000", {r_miso, done, err, core_start, core_dir});
    end
    reset = 1'b0;
    ce_down();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_ce_fall_err: got %b want 0", err); end
    s0 = start_cnt;
    ce_up();
    xfer({120'd0, 8'h03}, 8, rx_hdr);
    repeat (4) @(posedge clk);
    #2;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rmid_nokey_err: got %b want 1", err); end
    xfer(rnd128(), 128, rx);
    checks++; if (rx !== '0) begin errors++; $display("FAIL rmid_nokey_miso: got %h want 0", rx); end
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL rmid_nokey_starts: got %0d want 0", start_cnt - s0); end
    ce_down();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_key_reuse_decrypt();
    test_random();
    test_maxblk();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
